// File: rtl/temporizador_bus_lcd.sv
// temporizador_bus_lcd
// Bus-timing responder for an HD44780 LCD. Each accepted i_program starts one
// bus transaction. RS, RW and DB are driven for a setup time, then E is pulsed
// high for a pulse width, then RS/RW/DB are held. A recovery wait (optionally
// extended for slow LCD commands) follows before o_ready returns high. On
// reads, the data on i_lcd_db is captured on the edge where E falls.
//
// Handshake: o_ready=1 means idle. A transaction is accepted on any rising
// edge where o_ready=1 and i_program=1, and o_ready drops on that same edge.
// i_program is ignored while o_ready=0; it is not queued.
//
// Optional feature: define LCD_POWERON_INIT_EN to run the HD44780 power-on
// sequence from ST_ARRANQUE: a 15 ms wait, then three writes of 0x30 with
// 4.1 ms / 100 us / 40 us post-waits. This needs CNT_W >= 21.
// o_estado exposes the FSM state for debug.
module temporizador_bus_lcd #(
  parameter int unsigned T_AS_CYC   = 6,
  parameter int unsigned T_EPW_CYC  = 30,
  parameter int unsigned T_AH_CYC   = 2,
  parameter int unsigned T_REC_CYC  = 20,
  parameter int unsigned T_EXEC_CYC = 4000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_program,
  input  logic [3:0] i_control,
  input  logic [7:0] i_dato,
  output logic       o_ready,
  output logic [7:0] o_dato_leido,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db,
  output logic       o_lcd_db_oe,
  input  logic [7:0] i_lcd_db,
  output logic [2:0] o_estado
);

  typedef enum logic [2:0] {
    ST_ARRANQUE = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EHIGH    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_WAIT     = 3'd5
  } estado_t;

  // Each phase lasts max(T,1) cycles. The counter is loaded with that count
  // minus one and the phase ends on the edge where the counter is zero.
  localparam int unsigned AS_EFF   = (T_AS_CYC   == 0) ? 1 : T_AS_CYC;
  localparam int unsigned EPW_EFF  = (T_EPW_CYC  == 0) ? 1 : T_EPW_CYC;
  localparam int unsigned AH_EFF   = (T_AH_CYC   == 0) ? 1 : T_AH_CYC;
  localparam int unsigned REC_EFF  = (T_REC_CYC  == 0) ? 1 : T_REC_CYC;
  localparam int unsigned EXEC_EFF = (T_EXEC_CYC == 0) ? 1 : T_EXEC_CYC;

  localparam logic [CNT_W-1:0] AS_LD       = CNT_W'(AS_EFF - 1);
  localparam logic [CNT_W-1:0] EPW_LD      = CNT_W'(EPW_EFF - 1);
  localparam logic [CNT_W-1:0] AH_LD       = CNT_W'(AH_EFF - 1);
  localparam logic [CNT_W-1:0] REC_LD      = CNT_W'(REC_EFF - 1);
  localparam logic [CNT_W-1:0] REC_LONG_LD = CNT_W'(REC_EFF + EXEC_EFF - 1);

`ifdef LCD_POWERON_INIT_EN
  localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(1_500_000 - 1);
  localparam logic [CNT_W-1:0] POST0_LD  = CNT_W'(410_000 - 1);
  localparam logic [CNT_W-1:0] POST1_LD  = CNT_W'(10_000 - 1);
  localparam logic [CNT_W-1:0] POST2_LD  = CNT_W'(4_000 - 1);
  localparam logic [7:0]       INIT_BYTE = 8'h30;
`endif

  estado_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ready_n, e_n, rs_n, rw_n, oe_n;
  logic [7:0]       db_n, leido_n;
  logic             long_wait, long_n;

`ifdef LCD_POWERON_INIT_EN
  logic             init_activo, init_activo_n;
  logic [1:0]       init_paso, init_paso_n;
`endif

  // control[0] is reserved and intentionally unused
  logic unused_ctl;
  assign unused_ctl = i_control[0];

  assign o_estado = state;

  // State, timing counter and all pin/handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ARRANQUE;
      cnt          <= '0;
      o_ready      <= 1'b0;
      o_lcd_e      <= 1'b0;
      o_lcd_rs     <= 1'b0;
      o_lcd_rw     <= 1'b0;
      o_lcd_db     <= 8'h00;
      o_lcd_db_oe  <= 1'b0;
      o_dato_leido <= 8'h00;
      long_wait    <= 1'b0;
`ifdef LCD_POWERON_INIT_EN
      init_activo  <= 1'b1;
      init_paso    <= 2'd0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      o_ready      <= ready_n;
      o_lcd_e      <= e_n;
      o_lcd_rs     <= rs_n;
      o_lcd_rw     <= rw_n;
      o_lcd_db     <= db_n;
      o_lcd_db_oe  <= oe_n;
      o_dato_leido <= leido_n;
      long_wait    <= long_n;
`ifdef LCD_POWERON_INIT_EN
      init_activo  <= init_activo_n;
      init_paso    <= init_paso_n;
`endif
    end
  end

  // Next-state and next-register values; every register holds by default
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_n = o_ready;
    e_n     = o_lcd_e;
    rs_n    = o_lcd_rs;
    rw_n    = o_lcd_rw;
    db_n    = o_lcd_db;
    oe_n    = o_lcd_db_oe;
    leido_n = o_dato_leido;
    long_n  = long_wait;
`ifdef LCD_POWERON_INIT_EN
    init_activo_n = init_activo;
    init_paso_n   = init_paso;
`endif

    case (state)
      ST_ARRANQUE: begin
`ifdef LCD_POWERON_INIT_EN
        // Power-on wait, then launch the first 0x30 write (RS=0, RW=0)
        if (cnt == ARR_LAST) begin
          rs_n    = 1'b0;
          rw_n    = 1'b0;
          db_n    = INIT_BYTE;
          oe_n    = 1'b1;
          long_n  = 1'b0;
          cnt_n   = AS_LD;
          state_n = ST_SETUP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`else
        ready_n = 1'b1;
        state_n = ST_IDLE;
`endif
      end

      ST_IDLE: begin
        if (i_program) begin
          rs_n    = i_control[3];
          rw_n    = i_control[2];
          long_n  = i_control[1];
          db_n    = i_dato;
          oe_n    = ~i_control[2];
          ready_n = 1'b0;
          cnt_n   = AS_LD;
          state_n = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt == '0) begin
          e_n     = 1'b1;
          cnt_n   = EPW_LD;
          state_n = ST_EHIGH;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      ST_EHIGH: begin
        if (cnt == '0) begin
          e_n = 1'b0;
          if (o_lcd_rw) leido_n = i_lcd_db;
          cnt_n   = AH_LD;
          state_n = ST_HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt == '0) begin
          oe_n    = 1'b0;
          cnt_n   = long_wait ? REC_LONG_LD : REC_LD;
`ifdef LCD_POWERON_INIT_EN
          if (init_activo) begin
            case (init_paso)
              2'd0:    cnt_n = POST0_LD;
              2'd1:    cnt_n = POST1_LD;
              default: cnt_n = POST2_LD;
            endcase
          end
`endif
          state_n = ST_WAIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      ST_WAIT: begin
        if (cnt == '0) begin
          ready_n = 1'b1;
          state_n = ST_IDLE;
`ifdef LCD_POWERON_INIT_EN
          if (init_activo) begin
            if (init_paso == 2'd2) begin
              init_activo_n = 1'b0;
            end else begin
              // Next 0x30 write of the power-on sequence
              init_paso_n = init_paso + 2'd1;
              ready_n     = 1'b0;
              oe_n        = 1'b1;
              cnt_n       = AS_LD;
              state_n     = ST_SETUP;
            end
          end
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: begin
        ready_n = 1'b0;
        e_n     = 1'b0;
        oe_n    = 1'b0;
        cnt_n   = '0;
        state_n = ST_ARRANQUE;
      end
    endcase
  end

endmodule

// File: tb/tb_temporizador_bus_lcd.sv
// tb_temporizador_bus_lcd
// Directed bench for temporizador_bus_lcd at default timing parameters
// (default build, power-on init sequence disabled).
module tb_temporizador_bus_lcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_program = 1'b0;
  logic [3:0] i_control = 4'h0;
  logic [7:0] i_dato = 8'h00;
  logic [7:0] i_lcd_db = 8'h00;
  logic       o_ready, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_db_oe;
  logic [7:0] o_dato_leido, o_lcd_db;
  logic [2:0] o_estado;

  int errors = 0;
  int checks = 0;

  // Clock and reset
  always #5 clk = ~clk;

  temporizador_bus_lcd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_program    (i_program),
    .i_control    (i_control),
    .i_dato       (i_dato),
    .o_ready      (o_ready),
    .o_dato_leido (o_dato_leido),
    .o_lcd_rs     (o_lcd_rs),
    .o_lcd_rw     (o_lcd_rw),
    .o_lcd_e      (o_lcd_e),
    .o_lcd_db     (o_lcd_db),
    .o_lcd_db_oe  (o_lcd_db_oe),
    .i_lcd_db     (i_lcd_db),
    .o_estado     (o_estado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one transaction. Latency counts edges from accept to the edge where
  // the executor first samples o_ready=1. poke>=0 pulses i_program at that
  // negedge index while busy.
  task automatic run_txn(input string tag, input logic [3:0] ctl, input logic [7:0] d,
                         input int poke, input int exp_lat, input int exp_oe,
                         output logic [7:0] leido_fall);
    int lat, rise, high, pulses, oe_hi, pin_bad;
    logic prev_e;
    lat = -1; rise = -1; high = 0; pulses = 0; oe_hi = 0; pin_bad = 0;
    prev_e = 1'b0; leido_fall = 8'hxx;
    i_control = ctl; i_dato = d; i_program = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_drop"}, o_ready, 0);
    for (int n = 0; n < 6000; n++) begin
      if (n > 0) @(negedge clk);
      i_program = (n == poke);
      if ({o_lcd_rs, o_lcd_rw} != ctl[3:2]) pin_bad++;
      if (!ctl[2] && o_lcd_db != d) pin_bad++;
      if (o_lcd_e && !prev_e) begin
        pulses++;
        if (rise < 0) rise = n;
      end
      if (prev_e && !o_lcd_e) leido_fall = o_dato_leido;
      if (o_lcd_e) high++;
      if (o_lcd_db_oe) oe_hi++;
      prev_e = o_lcd_e;
      if (o_ready) begin
        lat = n + 1;
        break;
      end
    end
    i_program = 1'b0;
    check({tag, "_e_rise"}, rise, 6);
    check({tag, "_e_high"}, high, 30);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_oe_cycles"}, oe_hi, exp_oe);
    check({tag, "_pins_stable"}, pin_bad, 0);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_e_idle"}, {o_lcd_e, o_lcd_db_oe}, 0);
  endtask

  // Stimulus and checking
  initial begin
    logic [7:0] lf;
    int rises[$];
    logic prev_e;
    int lat;

    // Reset state
    #12;
    check("rst_ready", o_ready, 0);
    check("rst_e", o_lcd_e, 0);
    check("rst_rs_rw", {o_lcd_rs, o_lcd_rw}, 0);
    check("rst_db", o_lcd_db, 0);
    check("rst_oe", o_lcd_db_oe, 0);
    check("rst_leido", o_dato_leido, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arranque_ready", o_ready, 1);
    check("arranque_no_bus", {o_lcd_e, o_lcd_db_oe}, 0);

    // Write 0x41 with RS=1: oe high through setup+pulse+hold = 38 cycles
    run_txn("wr41", 4'b1000, 8'h41, -1, 59, 38, lf);
    check("wr41_leido", o_dato_leido, 8'h00);
    check("wr41_hold_pins", {o_lcd_rs, o_lcd_rw, o_lcd_db}, {2'b10, 8'h41});

    // Busy-flag read of 0x80, then a read of 0x00
    i_lcd_db = 8'h80;
    run_txn("rd80", 4'b0100, 8'hff, -1, 59, 0, lf);
    check("rd80_at_fall", lf, 8'h80);
    i_lcd_db = 8'h11;
    repeat (3) @(negedge clk);
    check("rd80_held", o_dato_leido, 8'h80);
    i_lcd_db = 8'h00;
    run_txn("rd00", 4'b0100, 8'h00, -1, 59, 0, lf);
    check("rd00_at_fall", lf, 8'h00);
    check("rd00_held", o_dato_leido, 8'h00);

    // LONG_WAIT write
    run_txn("long", 4'b0010, 8'h01, -1, 4059, 38, lf);

    // Read 0x5A, then a write with i_program poked during E high
    i_lcd_db = 8'h5a;
    run_txn("rd5a", 4'b1100, 8'h00, -1, 59, 0, lf);
    check("rd5a_at_fall", lf, 8'h5a);
    i_lcd_db = 8'h00;
    run_txn("poke", 4'b0000, 8'hc3, 15, 59, 38, lf);
    check("poke_leido_kept", o_dato_leido, 8'h5a);
    repeat (5) @(negedge clk);
    check("poke_not_queued", o_ready, 1);

    // i_program held high for 200 cycles: back-to-back transactions
    i_control = 4'b1000; i_dato = 8'h7e; i_program = 1'b1;
    prev_e = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_lcd_e && !prev_e) rises.push_back(n);
      prev_e = o_lcd_e;
    end
    i_program = 1'b0;
    check("held_pulses", rises.size(), 4);
    if (rises.size() >= 3) begin
      check("held_first_rise", rises[0], 6);
      check("held_period_a", rises[1] - rises[0], 59);
      check("held_period_b", rises[2] - rises[1], 59);
    end else begin
      check("held_rise_count_min", rises.size(), 3);
    end
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_ready) begin
        lat = n;
        break;
      end
    end
    check("held_drain_timeout", lat >= 0, 1);

    // Reset during E high
    i_control = 4'b1000; i_dato = 8'h77; i_program = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_program = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_e_high", o_lcd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_e", o_lcd_e, 0);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_oe", o_lcd_db_oe, 0);
    check("mid_rst_leido", o_dato_leido, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", o_ready, 1);
    check("post_rst_e", o_lcd_e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
